sram_dp_byte: RTL
=================

SRAM_DP_BYTE -- requirements
Module: sram_dp_byte

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 15, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Derived constant NB = DATA_W/8, the number of byte lanes.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 a_addr  in  ADDR_W  port A word address.
REQ-007 a_wr_en  in  1  port A write strobe.
REQ-008 a_be  in  NB  port A byte enables, bit i selects bits [8i+7:8i].
REQ-009 a_wr_data  in  DATA_W  port A write data.
REQ-010 a_rd_en  in  1  port A read strobe.
REQ-011 a_rd_data  out  DATA_W  port A read data, registered.
REQ-012 a_rd_valid  out  1  port A read data valid pulse.
REQ-013 b_addr  in  ADDR_W  port B (read-only) address.
REQ-014 b_rd_en  in  1  port B read strobe.
REQ-015 b_rd_data  out  DATA_W  port B read data, registered.
REQ-016 b_rd_valid  out  1  port B read data valid pulse.
REQ-017 clr_req  in  1  request a full-array clear.
REQ-018 err_inj  in  1  parity error injection on the current write.
REQ-019 busy  out  1  high while a clear sweep is in progress.
REQ-020 par_err  out  1  parity error pulse.

Function
REQ-021 FSM states: IDLE and CLEAR, with a clear counter clr_addr of ADDR_W bits.
REQ-022 In CLEAR, each cycle: word clr_addr <= 0, clr_addr increments; after the write of DEPTH-1 the FSM enters IDLE. A sweep lasts exactly DEPTH cycles.
REQ-023 IDLE with clr_req=1 -> CLEAR with clr_addr=0 next cycle; clr_req while in CLEAR is ignored and does not restart the sweep.
REQ-024 busy = 1 exactly while the FSM is in CLEAR.
REQ-025 In IDLE, a_wr_en=1 updates only the byte lanes of mem[a_addr] whose a_be bit is 1; a_be=0 writes nothing.
REQ-026 a_wr_en, a_rd_en and b_rd_en are ignored while busy=1: no write, and rd_valid stays 0.
REQ-027 Reads have a latency of 1: x_rd_en=1 in cycle N gives x_rd_data = mem[x_addr] and x_rd_valid=1 in cycle N+1; rd_valid is a single-cycle pulse per accepted read.
REQ-028 When no read is accepted, x_rd_data holds its last value.
REQ-029 Same-address read during a write (either port vs port A write) is read-first: the read returns the pre-write data.
REQ-030 Simultaneous port A and port B reads of any addresses, including equal ones, both complete in the same cycle.

Reset
REQ-031 rst=1 at an edge: FSM -> CLEAR and clr_addr=0, so busy=1 the next cycle.
REQ-032 rst=1 at an edge also sets a_rd_data=b_rd_data=0, a_rd_valid=b_rd_valid=0 and par_err=0.
REQ-033 rst asserted mid-sweep restarts the sweep from address 0.
REQ-034 The array SHALL also be zero at time 0 for simulation.

Configuration
REQ-035 Macro SRAM_DP_PARITY_EN defined: one even-parity bit is stored per byte lane and written with that lane's data. err_inj=1 with a write stores inverted parity on the enabled lanes. A clear stores correct parity for the zero data.
REQ-036 With SRAM_DP_PARITY_EN defined, on each accepted read the parity is recomputed. par_err=1 in the rd_valid cycle if any lane of either port mismatches; otherwise par_err=0.
REQ-037 Macro SRAM_DP_PARITY_EN undefined: no parity storage is built, err_inj is ignored, and par_err is tied to 0.

Structure
REQ-038 Package sram_dp_pkg SHALL hold the FSM state type (IDLE, CLEAR) and the byte-parity function.
REQ-039 The clear FSM and counter SHALL be in sub-module sram_dp_clr_seq (outputs busy, clr_we, clr_addr); the array and ports stay in sram_dp_byte.

Verification (DATA_W=32, ADDR_W=4)
REQ-040 Pulse rst, then hold idle -> busy=1 for exactly 16 cycles and then 0; reads of all 16 addresses return 0x00000000.
REQ-041 Write 0xAABBCCDD to addr 3 with a_be=4'hF, then write 0x11223344 with a_be=4'b0101 -> port B read of addr 3 returns 0xAA22CC44 with b_rd_valid one cycle after b_rd_en.
REQ-042 A write of 0x5 and a port B read of addr 7 in the same cycle (old value 0x9) -> b_rd_data=0x9; the next read returns 0x5.
REQ-043 clr_req during IDLE with addr 2 = 0xFF -> busy for 16 cycles, a_rd_en during busy gives no a_rd_valid, and a read afterwards returns 0.
REQ-044 Assert rst at sweep cycle 8 -> the sweep restarts and busy stays high for 16 more cycles.
REQ-045 With SRAM_DP_PARITY_EN, write addr 5 with err_inj=1 and a_be=4'b0010 -> reading addr 5 gives par_err=1 with a_rd_valid; reading addr 6 gives par_err=0.

Source files
------------

// File: rtl/sram_dp_pkg.sv
// Shared types and helpers for the byte-enable dual-port SRAM.
// Holds the clear-sequencer state encoding and the byte parity function.
package sram_dp_pkg;

  typedef logic [0:0] clr_state_t;

  localparam clr_state_t IDLE  = 1'b0;
  localparam clr_state_t CLEAR = 1'b1;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_dp_byte_if.sv
// Bus bundle for sram_dp_byte: port A read/write, port B read, clear and parity signals.
interface sram_dp_byte_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  localparam int NB = DATA_W / 8;

  logic [ADDR_W-1:0] a_addr;
  logic              a_wr_en;
  logic [NB-1:0]     a_be;
  logic [DATA_W-1:0] a_wr_data;
  logic              a_rd_en;
  logic [DATA_W-1:0] a_rd_data;
  logic              a_rd_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_rd_en;
  logic [DATA_W-1:0] b_rd_data;
  logic              b_rd_valid;
  logic              clr_req;
  logic              err_inj;
  logic              busy;
  logic              par_err;

  modport master (
    output a_addr, a_wr_en, a_be, a_wr_data, a_rd_en, b_addr, b_rd_en, clr_req, err_inj,
    input  a_rd_data, a_rd_valid, b_rd_data, b_rd_valid, busy, par_err
  );

  modport slave (
    input  a_addr, a_wr_en, a_be, a_wr_data, a_rd_en, b_addr, b_rd_en, clr_req, err_inj,
    output a_rd_data, a_rd_valid, b_rd_data, b_rd_valid, busy, par_err
  );

endinterface

// File: rtl/sram_dp_clr_seq.sv
// Clear sequencer: sweeps every word address once, one per cycle, after reset or clr_req.
module sram_dp_clr_seq
  import sram_dp_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          addr_d  = '0;
        end
      end
      CLEAR: begin
        // clr_req is deliberately ignored here so a sweep is never restarted.
        addr_d = addr_q + 1'b1;
        if (addr_q == LastAddr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = addr_q;

endmodule

// File: rtl/sram_dp_byte.sv
// Dual-port SRAM with byte enables: port A read/write, port B read-only, read-first.
// Optional per-lane even parity with error injection when SRAM_DP_PARITY_EN is defined.
module sram_dp_byte
  import sram_dp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input logic           clk,
  input logic           rst,
  sram_dp_byte_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sram_dp_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  logic a_wr_acc, a_rd_acc, b_rd_acc;
  assign a_wr_acc = bus.a_wr_en & ~busy;
  assign a_rd_acc = bus.a_rd_en & ~busy;
  assign b_rd_acc = bus.b_rd_en & ~busy;

  // Zero at time 0 so simulation matches the post-sweep state.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (a_wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.a_be[i]) mem[bus.a_addr][8*i +: 8] <= bus.a_wr_data[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0] a_rd_data_q, b_rd_data_q;
  logic              a_rd_valid_q, b_rd_valid_q;

  // Non-blocking array update gives read-first behaviour on address collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_data_q  <= '0;
      b_rd_data_q  <= '0;
      a_rd_valid_q <= 1'b0;
      b_rd_valid_q <= 1'b0;
    end else begin
      a_rd_valid_q <= a_rd_acc;
      b_rd_valid_q <= b_rd_acc;
      if (a_rd_acc) a_rd_data_q <= mem[bus.a_addr];
      if (b_rd_acc) b_rd_data_q <= mem[bus.b_addr];
    end
  end

  assign bus.a_rd_data  = a_rd_data_q;
  assign bus.a_rd_valid = a_rd_valid_q;
  assign bus.b_rd_data  = b_rd_data_q;
  assign bus.b_rd_valid = b_rd_valid_q;

`ifdef SRAM_DP_PARITY_EN
  // Parity of all-zero data is 0, so a zeroed parity array is consistent.
  logic [NB-1:0] par_mem [DEPTH] = '{default: '0};
  logic [NB-1:0] a_par_calc, b_par_calc;
  logic          par_err_q;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (a_wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.a_be[i]) begin
          par_mem[bus.a_addr][i] <= byte_parity(bus.a_wr_data[8*i +: 8]) ^ bus.err_inj;
        end
      end
    end
  end

  always_comb begin
    a_par_calc = '0;
    b_par_calc = '0;
    for (int i = 0; i < NB; i++) begin
      a_par_calc[i] = byte_parity(mem[bus.a_addr][8*i +: 8]);
      b_par_calc[i] = byte_parity(mem[bus.b_addr][8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= (a_rd_acc && (a_par_calc != par_mem[bus.a_addr])) ||
                   (b_rd_acc && (b_par_calc != par_mem[bus.b_addr]));
    end
  end

  assign bus.par_err = par_err_q;
`else
  logic unused_err_inj;
  assign unused_err_inj = bus.err_inj;
  assign bus.par_err    = 1'b0;
`endif

endmodule
